icache_fetch_server: RTL and testbench
======================================

// Module: icache_fetch_server
// PURPOSE
//  Memory-side responder for icache fill requests (iREN/iaddr -> iwait/iload) from CPUS cores.
//  Sits between the per-core icaches and the shared RAM port. Dcache traffic has priority via dbusy.
//  Round-robin arbitrates pending fetches and issues one RAM read per grant.
//  Drives iwait low for exactly one cycle with the fetched word.
// PARAMETERS
//  CPUS      2    number of icache requesters
//  WORD_W    32   data and address width
//  MAX_WAIT  255  RAM cycles allowed per fetch before abort; counter is 8 bits
// PORTS
//  CLK        in   1            clock, rising edge
//  nRST       in   1            synchronous, active-low reset
//  iREN       in   CPUS         per-core fetch request (level, held until iwait=0)
//  iaddr      in   CPUS*WORD_W  per-core fetch address, word-aligned
//  iwait      out  CPUS         per-core wait; 0 = iload valid this cycle
//  iload      out  CPUS*WORD_W  per-core fetched word
//  dbusy      in   1            dcache owns RAM; no new instruction grants
//  ramREN     out  1            RAM read enable
//  ramaddr    out  WORD_W       RAM address
//  ramload    in   WORD_W       RAM read data
//  ramstate   in   2            FREE=0 BUSY=1 ACCESS=2 ERROR=3 (ramstate_t)
//  fetch_err  out  1            sticky; set on MAX_WAIT timeout, cleared only by reset
// BEHAVIOUR
//  Reset (nRST=0 at posedge): state=IDLE, rr_ptr=0, grant=0, addr_q=0, wait_cnt=0, fetch_err=0.
//   All iwait=1, all iload=0, ramREN=0, ramaddr=0. Reset mid-fetch drops the fetch without a response.
//  FSM: IDLE, FETCH.
//   IDLE: ramREN=0. If dbusy=0 and any iREN=1, grant = first requester at or after rr_ptr (cyclic).
//    Latch addr_q=iaddr[grant], wait_cnt=0, go FETCH. If dbusy=1, stay IDLE.
//   FETCH: ramREN=1, ramaddr=addr_q. dbusy is ignored; an in-flight fetch always completes.
//    ramstate=ACCESS: iwait[grant]=0, iload[grant]=ramload (combinational, same cycle).
//     Next: rr_ptr=(grant+1) mod CPUS, go IDLE.
//    ramstate=ERROR: no response; go IDLE, rr_ptr unchanged. The requester keeps iREN high and is re-granted.
//    iREN[grant]=0 (abandoned fetch, e.g. redirect): go IDLE next cycle, no iwait pulse, rr_ptr unchanged.
//    FREE/BUSY: wait_cnt++. If wait_cnt reaches MAX_WAIT: set fetch_err, go IDLE, no response.
//  iwait[k]=1 in every cycle except the ACCESS cycle of core k's granted fetch.
//   iload[k]=0 whenever iwait[k]=1.
//  Latency: iREN rises in cycle t (IDLE, dbusy=0) -> FETCH at t+1 -> earliest iwait=0 at t+1 if ACCESS.
//  IDLE cycle follows every response, so back-to-back fetches are >=2 cycles apart.
//   With both cores requesting, grants alternate.
//  iaddr changes in FETCH are ignored; ramaddr uses latched addr_q.
//  Simultaneous ACCESS with iREN[grant] dropping: ACCESS wins; the response pulse is still issued.
//  Only one outstanding RAM read. ramREN never asserts in IDLE.
// TESTING
//  1. Core0 iREN=1, iaddr=0x40; RAM ACCESS 1 cycle after ramREN, ramload=0xDEADBEEF
//     -> ramaddr=0x40; iwait[0]=0 one cycle; iload[0]=0xDEADBEEF; iwait[1] stays 1.
//  2. Both cores request, 0x100/0x200, rr_ptr=0 -> core0 served first, then core1.
//     Alternation holds over 4 consecutive fetches each.
//  3. dbusy=1 for 5 cycles with core1 pending -> ramREN=0 throughout; grant in the first cycle dbusy=0.
//  4. ramstate=ERROR once, then ACCESS -> no pulse on ERROR; refetch of same address.
//     Exactly one iwait=0 pulse.
//  5. RAM stuck BUSY, MAX_WAIT=255 -> fetch_err=1 after 255 FETCH cycles; iwait stays 1; return to IDLE.
//  6. nRST=0 mid-FETCH -> next cycle: all outputs at reset values; no stale iwait=0 after reset.

Source files
------------

// File: rtl/icache_fetch_server.sv
// icache fill responder: round-robin arbitration of per-core fetches
// onto one shared RAM read port, yielding new grants to dcache traffic.

package icache_fetch_pkg;
  typedef enum logic [1:0] {
    RS_FREE   = 2'd0,
    RS_BUSY   = 2'd1,
    RS_ACCESS = 2'd2,
    RS_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fsm_t;
endpackage

module icache_fetch_server
  import icache_fetch_pkg::*;
#(
  parameter int CPUS     = 2,
  parameter int WORD_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic                   dbusy,
  output logic                   ramREN,
  output logic [WORD_W-1:0]      ramaddr,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic                   fetch_err
);

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  fsm_t             state, state_n;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_n;
  logic [PTR_W-1:0] grant, grant_n;
  logic [PTR_W-1:0] pick, cand, rr_adv;
  logic [WORD_W-1:0] addr_q, addr_n;
  logic [7:0]       wait_cnt, wait_cnt_n;
  logic             err_n;
  logic             hit;
  logic             acc, drop, tmo;
  logic [WORD_W-1:0] addr_arr [CPUS];
  ramstate_t        rs;

  assign rs = ramstate_t'(ramstate);

  always_comb begin
    for (int k = 0; k < CPUS; k++) begin
      addr_arr[k] = iaddr[k*WORD_W +: WORD_W];
    end
  end

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 0; k < CPUS; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % CPUS);
      if (!hit && iREN[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  assign rr_adv = (grant == PTR_W'(CPUS - 1)) ? '0 : grant + 1'b1;

  // ACCESS outranks error/abandon, which outrank the timeout
  assign acc  = (state == S_FETCH) && (rs == RS_ACCESS);
  assign drop = (state == S_FETCH) && !acc &&
                ((rs == RS_ERROR) || !iREN[grant]);
  assign tmo  = (state == S_FETCH) && !acc && !drop &&
                (wait_cnt == WAIT_LAST);

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    grant_n    = grant;
    addr_n     = addr_q;
    wait_cnt_n = wait_cnt;
    err_n      = fetch_err;
    unique case (state)
      S_IDLE: begin
        if (!dbusy && hit) begin
          grant_n    = pick;
          addr_n     = addr_arr[pick];
          wait_cnt_n = '0;
          state_n    = S_FETCH;
        end
      end
      S_FETCH: begin
        unique case (1'b1)
          acc: begin
            rr_ptr_n = rr_adv;
            state_n  = S_IDLE;
          end
          drop: begin
            state_n = S_IDLE;
          end
          tmo: begin
            wait_cnt_n = wait_cnt + 8'd1;
            err_n      = 1'b1;
            state_n    = S_IDLE;
          end
          default: begin
            wait_cnt_n = wait_cnt + 8'd1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    ramREN  = (state == S_FETCH);
    ramaddr = (state == S_FETCH) ? addr_q : '0;
    for (int k = 0; k < CPUS; k++) begin
      iwait[k] = !(acc && (grant == PTR_W'(k)));
      iload[k*WORD_W +: WORD_W] =
        (acc && (grant == PTR_W'(k))) ? ramload : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      addr_q    <= '0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      grant     <= grant_n;
      addr_q    <= addr_n;
      wait_cnt  <= wait_cnt_n;
      fetch_err <= err_n;
    end
  end

  a_one_resp: assert property (
    @(posedge CLK) disable iff (!nRST) $onehot0(~iwait));

  a_idle_quiet: assert property (
    @(posedge CLK) disable iff (!nRST)
    (state == S_IDLE) |-> (!ramREN && (&iwait)));

  a_load_zero: assert property (
    @(posedge CLK) disable iff (!nRST)
    (&iwait) |-> (iload == '0));

endmodule

// File: tb/tb_icache_fetch_server.sv
// Bench for icache_fetch_server: vector table, corner sequences,
// and randomized traffic against a transaction-level model.

module tb_icache_fetch_server;

  localparam logic [1:0] FR = 2'd0;
  localparam logic [1:0] BZ = 2'd1;
  localparam logic [1:0] AC = 2'd2;
  localparam logic [1:0] ER = 2'd3;

  logic        CLK;
  logic        nRST;
  logic [1:0]  iREN;
  logic [63:0] iaddr;
  logic [1:0]  iwait;
  logic [63:0] iload;
  logic        dbusy;
  logic        ramREN;
  logic [31:0] ramaddr;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        fetch_err;

  icache_fetch_server #(
    .CPUS(2), .WORD_W(32), .MAX_WAIT(255)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .dbusy(dbusy),
    .ramREN(ramREN), .ramaddr(ramaddr),
    .ramload(ramload), .ramstate(ramstate),
    .fetch_err(fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ren;
    logic [31:0] a0, a1;
    logic        db;
    logic [1:0]  rs;
    logic [31:0] ld;
    logic [1:0]  e_iwait;
    logic [63:0] e_iload;
    logic        e_ren;
    logic [31:0] e_raddr;
  } vec_t;

  vec_t tbl[$];

  // transaction-level model: one outstanding fetch record
  bit          m_busy;
  int          m_core;
  logic [31:0] m_addr;
  int          m_waited;
  int          m_rr;
  bit          m_err;
  logic [1:0]  m_iwait;
  logic [63:0] m_iload;
  logic        m_ren;
  logic [31:0] m_raddr;
  logic        m_fe;

  task automatic model_eval(input logic rst, input logic [1:0] ren,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic db, input logic [1:0] rs,
                            input logic [31:0] ld);
    logic [31:0] a[2];
    a[0] = a0;
    a[1] = a1;
    m_iwait = 2'b11;
    m_iload = '0;
    m_ren   = m_busy;
    m_raddr = m_busy ? m_addr : 32'h0;
    m_fe    = m_err;
    if (m_busy && rs == AC) begin
      m_iwait[m_core] = 1'b0;
      m_iload[m_core*32 +: 32] = ld;
    end
    if (!rst) begin
      m_busy = 0; m_rr = 0; m_err = 0;
      m_addr = 0; m_waited = 0; m_core = 0;
    end else if (!m_busy) begin
      if (!db) begin
        for (int off = 0; off < 2; off++) begin
          int c;
          c = (m_rr + off) % 2;
          if (ren[c] && !m_busy) begin
            m_busy = 1; m_core = c;
            m_addr = a[c]; m_waited = 0;
          end
        end
      end
    end else if (rs == AC) begin
      m_busy = 0;
      m_rr = (m_core + 1) % 2;
    end else if (rs == ER || !ren[m_core]) begin
      m_busy = 0;
    end else begin
      m_waited++;
      if (m_waited >= 255) begin
        m_err = 1;
        m_busy = 0;
      end
    end
  endtask

  task automatic apply(input logic rst, input logic [1:0] ren,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic db, input logic [1:0] rs,
                       input logic [31:0] ld);
    @(negedge CLK);
    nRST = rst; iREN = ren; iaddr = {a1, a0};
    dbusy = db; ramstate = rs; ramload = ld;
    #2;
    model_eval(rst, ren, a0, a1, db, rs, ld);
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input logic [1:0] ew,
                     input logic [63:0] el, input logic er,
                     input logic [31:0] ea, input logic ee);
    chk({tag, ".iwait"}, 64'(iwait), 64'(ew));
    chk({tag, ".iload"}, iload, el);
    chk({tag, ".ramREN"}, 64'(ramREN), 64'(er));
    chk({tag, ".ramaddr"}, 64'(ramaddr), 64'(ea));
    chk({tag, ".fetch_err"}, 64'(fetch_err), 64'(ee));
  endtask

  task automatic v(input logic [1:0] ren, input logic [31:0] a0,
                   input logic [31:0] a1, input logic db,
                   input logic [1:0] rs, input logic [31:0] ld,
                   input logic [1:0] ew, input logic [31:0] e0,
                   input logic [31:0] e1, input logic er,
                   input logic [31:0] ea);
    vec_t t;
    t.ren = ren; t.a0 = a0; t.a1 = a1; t.db = db;
    t.rs = rs; t.ld = ld; t.e_iwait = ew;
    t.e_iload = {e1, e0}; t.e_ren = er; t.e_raddr = ea;
    tbl.push_back(t);
  endtask

  task automatic fill();
    // reset values
    v(2'b00, 0, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    // single fetch core0, ACCESS one cycle after ramREN
    v(2'b01, 32'h40, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    v(2'b01, 32'h40, 0, 0, BZ, 0, 2'b11, 0, 0, 1, 32'h40);
    v(2'b01, 32'h40, 0, 0, AC, 32'hDEADBEEF,
      2'b10, 32'hDEADBEEF, 0, 1, 32'h40);
    v(2'b00, 32'h40, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    // dbusy holds off core1, then dbusy ignored in FETCH
    for (int i = 0; i < 5; i++)
      v(2'b10, 0, 32'h300, 1, AC, 32'h55, 2'b11, 0, 0, 0, 0);
    v(2'b10, 0, 32'h300, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    v(2'b10, 0, 32'h300, 1, AC, 32'h12345678,
      2'b01, 0, 32'h12345678, 1, 32'h300);
    v(2'b00, 0, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    // both request; alternation, iaddr changes during FETCH ignored
    for (int i = 0; i < 4; i++) begin
      v(2'b11, 32'h100, 32'h200, 0, AC, 32'hF0 + i,
        2'b11, 0, 0, 0, 0);
      v(2'b11, 32'h999, 32'h888, 0, AC, 32'hA0 + i,
        2'b10, 32'hA0 + i, 0, 1, 32'h100);
      v(2'b11, 32'h100, 32'h200, 0, AC, 32'hE0 + i,
        2'b11, 0, 0, 0, 0);
      v(2'b11, 32'h777, 32'h666, 0, AC, 32'hB0 + i,
        2'b01, 0, 32'hB0 + i, 1, 32'h200);
    end
    v(2'b00, 0, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    // ERROR then refetch of the same address
    v(2'b01, 32'h80, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    v(2'b01, 32'h80, 0, 0, ER, 32'hBAD, 2'b11, 0, 0, 1, 32'h80);
    v(2'b01, 32'h80, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    v(2'b01, 32'h80, 0, 0, AC, 32'hCAFEF00D,
      2'b10, 32'hCAFEF00D, 0, 1, 32'h80);
    v(2'b00, 0, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    // abandoned fetch keeps rr on core1
    v(2'b10, 0, 32'h44, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    v(2'b00, 0, 32'h44, 0, BZ, 0, 2'b11, 0, 0, 1, 32'h44);
    v(2'b00, 0, 32'h44, 0, AC, 32'h11, 2'b11, 0, 0, 0, 0);
    v(2'b11, 32'h50, 32'h48, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    // drop coincides with ACCESS: pulse still issued
    v(2'b01, 32'h50, 32'h48, 0, AC, 32'h77,
      2'b01, 0, 32'h77, 1, 32'h48);
    v(2'b01, 32'h50, 32'h48, 0, FR, 0, 2'b11, 0, 0, 0, 0);
    v(2'b01, 32'h50, 32'h48, 0, AC, 32'h88,
      2'b10, 32'h88, 0, 1, 32'h50);
    v(2'b00, 0, 0, 0, FR, 0, 2'b11, 0, 0, 0, 0);
  endtask

  logic [1:0]  req;
  logic [31:0] ra[2];
  logic [1:0]  rsr;
  logic        dbr;
  int          r;

  initial begin
    nRST = 1'b0; iREN = '0; iaddr = '0; dbusy = 1'b0;
    ramstate = FR; ramload = '0;
    m_busy = 0; m_rr = 0; m_err = 0; m_core = 0;
    m_addr = 0; m_waited = 0;
    fill();
    apply(0, 2'b00, 0, 0, 0, FR, 0);
    apply(0, 2'b00, 0, 0, 0, FR, 0);

    foreach (tbl[i]) begin
      apply(1, tbl[i].ren, tbl[i].a0, tbl[i].a1,
            tbl[i].db, tbl[i].rs, tbl[i].ld);
      cmp($sformatf("vec%0d", i), tbl[i].e_iwait, tbl[i].e_iload,
          tbl[i].e_ren, tbl[i].e_raddr, 1'b0);
    end

    // RAM stuck BUSY: 255 FETCH cycles then timeout
    apply(1, 2'b01, 32'h60, 0, 0, BZ, 0);
    chk("tmo.grant_ren", 64'(ramREN), 0);
    for (int n = 0; n < 255; n++) begin
      apply(1, 2'b01, 32'h60, 0, 0, BZ, 32'h5A);
      chk($sformatf("tmo%0d.ren", n), 64'(ramREN), 1);
      chk($sformatf("tmo%0d.iwait", n), 64'(iwait), 3);
      chk($sformatf("tmo%0d.err", n), 64'(fetch_err), 0);
    end
    apply(1, 2'b01, 32'h60, 0, 0, BZ, 0);
    chk("tmo.idle_ren", 64'(ramREN), 0);
    chk("tmo.idle_iwait", 64'(iwait), 3);
    chk("tmo.err_set", 64'(fetch_err), 1);
    apply(1, 2'b00, 32'h60, 0, 0, FR, 0);
    chk("tmo.err_sticky", 64'(fetch_err), 1);
    apply(1, 2'b00, 0, 0, 0, FR, 0);

    // reset in the middle of a fetch
    apply(1, 2'b01, 32'h70, 0, 0, FR, 0);
    apply(1, 2'b01, 32'h70, 0, 0, BZ, 0);
    chk("rst.pre_ren", 64'(ramREN), 1);
    chk("rst.pre_addr", 64'(ramaddr), 64'h70);
    apply(0, 2'b01, 32'h70, 0, 0, BZ, 0);
    apply(1, 2'b01, 32'h70, 0, 0, AC, 32'h99);
    cmp("rst.after", 2'b11, 64'h0, 1'b0, 32'h0, 1'b0);
    apply(1, 2'b01, 32'h70, 0, 0, AC, 32'h99);
    cmp("rst.resume", 2'b10, 64'h99, 1'b1, 32'h70, 1'b0);
    apply(1, 2'b00, 0, 0, 0, FR, 0);

    // randomized traffic against the model
    req = '0;
    ra[0] = 0;
    ra[1] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!req[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[k] = 1'b1;
            ra[k] = $urandom & ~32'h3;
          end
        end else if (!m_iwait[k]) begin
          req[k] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          req[k] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          ra[k] = $urandom & ~32'h3;
        end
      end
      dbr = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      rsr = (r < 4) ? AC : (r < 7) ? BZ : (r < 9) ? FR : ER;
      apply(1, req, ra[0], ra[1], dbr, rsr, $urandom);
      cmp($sformatf("rand%0d", cyc), m_iwait, m_iload,
          m_ren, m_raddr, m_fe);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
